// File: rtl/pe_mp_mac.sv
// pe_mp_mac: multi-precision MAC processing element.
//   Streams operand beats over valid/ready, accumulates a dot product and
//   emits one result per vector (in_last marks the final beat).
//   precision_mode: 00 signed full width, 01 two signed half-width lanes,
//                   10 four signed quarter-width lanes, 11 unsigned full width.
//   Optional build macro SATURATE_EN: clamp each accumulate to the signed
//   OUTPUT_WIDTH range and report it on sat_flag. Undefined: wrap, sat_flag=0.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   precision_mode           lane format, latched on a vector's first beat
//   in_valid/in_ready/in_last, data_in_1/data_in_2   operand stream
//   out_valid/out_ready, data_out, sat_flag           result stream
module pe_mp_mac #(
  parameter int INPUT_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              precision_mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [INPUT_WIDTH-1:0]  data_in_1,
  input  logic [INPUT_WIDTH-1:0]  data_in_2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUTPUT_WIDTH-1:0] data_out,
  output logic                    sat_flag
);
  localparam int W  = INPUT_WIDTH;
  localparam int OW = OUTPUT_WIDTH;
  localparam int H  = W / 2;
  localparam int Q  = W / 4;
  localparam int PW = 2 * W + 1;  // holds any lane sum, incl. unsigned product
  localparam int EW = OW + 1;     // stage-1 width: unsigned product stays positive
  localparam int SW = OW + 2;     // accumulate width: room to detect overflow

  generate
    if (W < 4 || (W % 4) != 0) begin : g_bad_in
      $error("pe_mp_mac: INPUT_WIDTH must be a positive multiple of 4");
    end
    if (OW < 2 * W) begin : g_bad_out
      $error("pe_mp_mac: OUTPUT_WIDTH must be >= 2*INPUT_WIDTH");
    end
  endgenerate

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACC   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] OUT   = 2'd3;

  logic [1:0] state, mode_q, eff_mode;
  logic       beat;

  assign in_ready = !rst && (state == IDLE || state == ACC);
  assign beat     = in_valid && in_ready;
  // First beat uses the live mode; the rest of the vector uses the latched one.
  assign eff_mode = (state == IDLE) ? precision_mode : mode_q;

  // Lane products, summed in a width that cannot overflow.
  logic signed [PW-1:0] la, lb, lane_sum;
  always_comb begin
    la       = '0;
    lb       = '0;
    lane_sum = '0;
    case (eff_mode)
      2'b00: begin
        la       = PW'($signed(data_in_1));
        lb       = PW'($signed(data_in_2));
        lane_sum = la * lb;
      end
      2'b01: begin
        for (int i = 0; i < 2; i++) begin
          la       = PW'($signed(data_in_1[i*H +: H]));
          lb       = PW'($signed(data_in_2[i*H +: H]));
          lane_sum = lane_sum + la * lb;
        end
      end
      2'b10: begin
        for (int i = 0; i < 4; i++) begin
          la       = PW'($signed(data_in_1[i*Q +: Q]));
          lb       = PW'($signed(data_in_2[i*Q +: Q]));
          lane_sum = lane_sum + la * lb;
        end
      end
      default: begin
        la       = PW'(data_in_1);
        lb       = PW'(data_in_2);
        lane_sum = la * lb;
      end
    endcase
  end

  // Stage 1: registered product, tagged with first-beat-of-vector.
  logic                 s1_vld, s1_first;
  logic signed [EW-1:0] s1_prod;

  // Stage 2: accumulator. The first product of a vector replaces the old value.
  logic signed [OW-1:0] acc, acc_nxt;
  logic signed [OW-1:0] base;
  logic signed [SW-1:0] sum;
  logic                 ovf;

  always_comb begin
    base = s1_first ? '0 : acc;
    sum  = SW'(base) + SW'(s1_prod);
`ifdef SATURATE_EN
    // Overflow when the bits above the signed OW range are not a sign copy.
    ovf     = (|sum[SW-1:OW-1]) && !(&sum[SW-1:OW-1]);
    acc_nxt = !ovf ? sum[OW-1:0]
            : (sum[SW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}});
`else
    ovf     = 1'b0;
    acc_nxt = sum[OW-1:0];
`endif
  end

`ifdef SATURATE_EN
  logic sat_acc;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mode_q    <= 2'b00;
      s1_vld    <= 1'b0;
      s1_first  <= 1'b0;
      s1_prod   <= '0;
      acc       <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
`ifdef SATURATE_EN
      sat_acc   <= 1'b0;
      sat_flag  <= 1'b0;
`endif
    end else begin
      s1_vld <= beat;
      if (beat) begin
        s1_prod  <= EW'(lane_sum);
        s1_first <= (state == IDLE);
      end
      if (s1_vld) begin
        acc <= acc_nxt;
`ifdef SATURATE_EN
        sat_acc <= s1_first ? ovf : (sat_acc | ovf);
`endif
      end
      case (state)
        IDLE: if (beat) begin
          mode_q <= precision_mode;
          state  <= in_last ? DRAIN : ACC;
        end
        ACC: if (beat && in_last) state <= DRAIN;
        // Wait one cycle for the last product to fold, then publish.
        DRAIN: if (!s1_vld) begin
          data_out  <= acc;
          out_valid <= 1'b1;
`ifdef SATURATE_EN
          sat_flag  <= sat_acc;
`endif
          state     <= OUT;
        end
        default: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifndef SATURATE_EN
  assign sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_pe_mp_mac.sv
// Directed bench for pe_mp_mac: one 8/32 instance and one 8/16 instance
// (overflow case). 'sel' steers the stream to one of them.
module tb_pe_mp_mac;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic       iv, il, ory, sel;
  logic [7:0] a, b;

  logic        r32, ov32, s32, r16, ov16, s16;
  logic [31:0] d32;
  logic [15:0] d16;
  logic        rdy, ov, sf;
  logic [31:0] dm;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pe_mp_mac #(.INPUT_WIDTH(8), .OUTPUT_WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .precision_mode(mode),
    .in_valid(iv && !sel), .in_ready(r32), .in_last(il),
    .data_in_1(a), .data_in_2(b),
    .out_valid(ov32), .out_ready(ory && !sel), .data_out(d32), .sat_flag(s32));

  pe_mp_mac #(.INPUT_WIDTH(8), .OUTPUT_WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .precision_mode(mode),
    .in_valid(iv && sel), .in_ready(r16), .in_last(il),
    .data_in_1(a), .data_in_2(b),
    .out_valid(ov16), .out_ready(ory && sel), .data_out(d16), .sat_flag(s16));

  assign rdy = sel ? r16 : r32;
  assign ov  = sel ? ov16 : ov32;
  assign sf  = sel ? s16 : s32;
  assign dm  = sel ? {16'h0, d16} : d32;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one beat from a negedge; it transfers at the following posedge.
  task automatic beat(input logic [1:0] m, input logic [7:0] x, input logic [7:0] y,
                      input logic last);
    int n = 0;
    @(negedge clk);
    while (!rdy && n < 50) begin @(negedge clk); n++; end
    if (!rdy) chk("beat_ready_timeout", 32'(rdy), 32'd1);
    mode = m; a = x; b = y; il = last; iv = 1'b1;
    @(posedge clk);
    #1 iv = 1'b0; il = 1'b0;
  endtask

  // Wait (bounded) for out_valid, capture the result and accept it.
  task automatic take(output logic [31:0] d, output logic s, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!ov && n < 50);
    if (!ov) chk("result_timeout", 32'(ov), 32'd1);
    d = dm; s = sf;
    ory = 1'b1;
    @(posedge clk);
    #1 ory = 1'b0;
  endtask

  logic [31:0] d;
  logic        s;
  int          n;

  initial begin
    rst = 1'b1; sel = 1'b0; iv = 1'b0; il = 1'b0; ory = 1'b0;
    mode = 2'b00; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(r32), 32'd0);
    chk("rst_out_valid", 32'(ov32), 32'd0);
    chk("rst_data_out", d32, 32'd0);
    chk("rst_sat_flag", 32'(s32), 32'd0);
    rst = 1'b0;

    // 3*4 + (-2)*5 + 7*7 = 51
    beat(2'b00, 8'd3, 8'd4, 1'b0);
    beat(2'b00, 8'hFE, 8'd5, 1'b0);
    beat(2'b00, 8'd7, 8'd7, 1'b1);
    @(negedge clk);
    chk("drain_in_ready", 32'(rdy), 32'd0);
    chk("drain_out_valid", 32'(ov), 32'd0);
    take(d, s, n);
    chk("m00_dot", d, 32'd51);
    // Second negedge after the first one above = just after the 2nd edge.
    chk("m00_latency", 32'(n), 32'd2);
    chk("m00_sat", 32'(s), 32'd0);

    // lanes (-1,3)x(2,2) = 4
    beat(2'b01, 8'h3F, 8'h22, 1'b1);
    take(d, s, n);
    chk("m01_dot", d, 32'd4);

    // lanes (-2,-1,1,1)x(1,1,1,1) = -1
    beat(2'b10, 8'b01_01_11_10, 8'h55, 1'b1);
    take(d, s, n);
    chk("m10_dot", d, 32'hFFFF_FFFF);

    beat(2'b11, 8'hFF, 8'hFF, 1'b1);
    take(d, s, n);
    chk("m11_dot", d, 32'd65025);
    chk("m11_sat", 32'(s), 32'd0);

    beat(2'b00, 8'hFF, 8'hFF, 1'b1);
    take(d, s, n);
    chk("m00_ff", d, 32'd1);

    // Gap mid-vector and a mode change on beat 2 (ignored): 25 + 1 = 26
    beat(2'b00, 8'd5, 8'd5, 1'b0);
    repeat (3) @(posedge clk);
    beat(2'b11, 8'hFF, 8'hFF, 1'b1);
    take(d, s, n);
    chk("gap_mode_hold", d, 32'd26);

    // Backpressure: hold out_ready low for 5 cycles after the result appears.
    beat(2'b00, 8'd10, 8'd10, 1'b1);
    n = 0;
    do begin @(negedge clk); n++; end while (!ov && n < 50);
    for (int i = 0; i < 5; i++) begin
      chk("bp_data", dm, 32'd100);
      chk("bp_in_ready", 32'(rdy), 32'd0);
      @(negedge clk);
    end
    ory = 1'b1;
    @(posedge clk);
    #1 ory = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", 32'(rdy), 32'd1);
    chk("rel_out_valid", 32'(ov), 32'd0);
    beat(2'b00, 8'd2, 8'd2, 1'b1);
    take(d, s, n);
    chk("after_bp", d, 32'd4);

    // 16-bit accumulator: 16384 + 16384 overflows the signed range.
    sel = 1'b1;
    beat(2'b00, 8'h80, 8'h80, 1'b0);
    beat(2'b00, 8'h80, 8'h80, 1'b1);
    take(d, s, n);
`ifdef SATURATE_EN
    chk("ow16_data", d, 32'h0000_7FFF);
    chk("ow16_sat", 32'(s), 32'd1);
`else
    chk("ow16_data", d, 32'h0000_8000);
    chk("ow16_sat", 32'(s), 32'd0);
`endif
    sel = 1'b0;

    // Reset after two beats discards the partial vector.
    beat(2'b00, 8'd9, 8'd9, 1'b0);
    beat(2'b00, 8'd9, 8'd9, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_out_valid", 32'(ov), 32'd0);
    chk("mrst_in_ready", 32'(rdy), 32'd0);
    chk("mrst_data", dm, 32'd0);
    rst = 1'b0;
    beat(2'b00, 8'd2, 8'd3, 1'b1);
    take(d, s, n);
    chk("mrst_next", d, 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
